dm_access_arbiter: RTL and testbench

Shares one synchronous single-port data BRAM (1-cycle read latency, 4-bit byte-write enable) between two requesters. Port 0 is the CPU load/store unit. Port 1 is the debug/loader port. For each granted request the block does:
- round-robin arbitration;
- sequencing of the BRAM enable and write-enable;
- write-lane steering and read-lane extraction/extension by address and size code;
- misalignment rejection.
A single done/error handshake returns the result to the requester.

---
 rtl/dm_access_arbiter.sv | 182 ++++++++++++++++++
 tb/tb_dm_access_arbiter.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/dm_access_arbiter.sv
// Two-port round-robin front end for a single-port, byte-enabled data BRAM:
// arbitration, write-lane steering, read-lane extraction/extension and misalignment rejection.
module dm_access_arbiter #(
  parameter int DM_AW = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             m0_req,
  input  logic             m0_we,
  input  logic [31:0]      m0_addr,
  input  logic [31:0]      m0_wdata,
  input  logic [2:0]       m0_ctrl,
  output logic             m0_ack,
  output logic             m0_err,
  output logic [31:0]      m0_rdata,
  input  logic             m1_req,
  input  logic             m1_we,
  input  logic [31:0]      m1_addr,
  input  logic [31:0]      m1_wdata,
  input  logic [2:0]       m1_ctrl,
  output logic             m1_ack,
  output logic             m1_err,
  output logic [31:0]      m1_rdata,
  output logic             dm_en,
  output logic [3:0]       dm_wea,
  output logic [DM_AW-1:0] dm_addr,
  output logic [31:0]      dm_din,
  input  logic [31:0]      dm_dout,
  output logic             busy
);

  localparam int LAW = DM_AW + 2;

  typedef enum logic [1:0] {IDLE, ISSUE, RESP, ERR} state_t;
  typedef enum logic [1:0] {SZ_WORD, SZ_HALF, SZ_BYTE} size_t;

  function automatic size_t size_of(input logic [2:0] ctrl);
    case (ctrl)
      3'b001, 3'b010: size_of = SZ_HALF;
      3'b011, 3'b100: size_of = SZ_BYTE;
      default:        size_of = SZ_WORD;
    endcase
  endfunction

  function automatic logic misaligned(input logic [1:0] a, input logic [2:0] ctrl);
    case (size_of(ctrl))
      SZ_WORD: misaligned = (a != 2'b00);
      SZ_HALF: misaligned = a[0];
      default: misaligned = 1'b0;
    endcase
  endfunction

  state_t          state_q, state_d;
  logic            rr_last_q;
  logic            gnt_q;
  logic            we_q;
  logic [LAW-1:0]  addr_q;
  logic [31:0]     wdata_q;
  logic [2:0]      ctrl_q;

  // Port selection in IDLE; on a tie the port that did not win the last tie goes.
  logic            any_req, both_req, pick;
  logic            sel_we;
  logic [LAW-1:0]  sel_addr;
  logic [31:0]     sel_wdata;
  logic [2:0]      sel_ctrl;

  assign any_req   = m0_req | m1_req;
  assign both_req  = m0_req & m1_req;
  assign pick      = both_req ? ~rr_last_q : m1_req;
  assign sel_we    = pick ? m1_we               : m0_we;
  assign sel_addr  = pick ? m1_addr[LAW-1:0]    : m0_addr[LAW-1:0];
  assign sel_wdata = pick ? m1_wdata            : m0_wdata;
  assign sel_ctrl  = pick ? m1_ctrl             : m0_ctrl;

  logic unused_addr_bits;
  assign unused_addr_bits = ^{m0_addr[31:LAW], m1_addr[31:LAW]};

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      rr_last_q <= 1'b1;
      gnt_q     <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      ctrl_q    <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && any_req) begin
        gnt_q   <= pick;
        we_q    <= sel_we;
        addr_q  <= sel_addr;
        wdata_q <= sel_wdata;
        ctrl_q  <= sel_ctrl;
        if (both_req) rr_last_q <= pick;
      end
    end
  end

  logic             ack, err, en, ld_signed;
  logic [3:0]       wea;
  logic [31:0]      din, rdata;
  logic [DM_AW-1:0] waddr;
  logic [15:0]      half_lane;
  logic [7:0]       byte_lane;

  assign ld_signed = (ctrl_q == 3'b001) || (ctrl_q == 3'b011);
  assign half_lane = addr_q[1] ? dm_dout[31:16] : dm_dout[15:0];
  assign byte_lane = dm_dout[{addr_q[1:0], 3'b000} +: 8];

  // NOTE: every signal gets a default before the case so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    ack     = 1'b0;
    err     = 1'b0;
    en      = 1'b0;
    wea     = '0;
    din     = '0;
    rdata   = '0;
    waddr   = '0;
    case (state_q)
      IDLE: begin
        if (any_req) state_d = misaligned(sel_addr[1:0], sel_ctrl) ? ERR : ISSUE;
      end
      ISSUE: begin
        en    = 1'b1;
        waddr = addr_q[LAW-1:2];
        if (we_q) begin
          ack     = 1'b1;
          state_d = IDLE;
          case (size_of(ctrl_q))
            SZ_HALF: begin
              wea = addr_q[1] ? 4'b1100 : 4'b0011;
              din = {2{wdata_q[15:0]}};
            end
            SZ_BYTE: begin
              wea = 4'b0001 << addr_q[1:0];
              din = {4{wdata_q[7:0]}};
            end
            default: begin
              wea = 4'b1111;
              din = wdata_q;
            end
          endcase
        end else begin
          state_d = RESP;
        end
      end
      RESP: begin
        ack     = 1'b1;
        state_d = IDLE;
        case (size_of(ctrl_q))
          SZ_HALF: rdata = {{16{ld_signed & half_lane[15]}}, half_lane};
          SZ_BYTE: rdata = {{24{ld_signed & byte_lane[7]}}, byte_lane};
          default: rdata = dm_dout;
        endcase
      end
      ERR: begin
        ack     = 1'b1;
        err     = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Reset gates every output combinationally so a reset in ISSUE aborts the write.
  assign m0_ack   = ack & ~gnt_q & ~rst;
  assign m1_ack   = ack &  gnt_q & ~rst;
  assign m0_err   = err & ~gnt_q & ~rst;
  assign m1_err   = err &  gnt_q & ~rst;
  assign m0_rdata = (~gnt_q & ~rst) ? rdata : '0;
  assign m1_rdata = ( gnt_q & ~rst) ? rdata : '0;
  assign dm_en    = en & ~rst;
  assign dm_wea   = rst ? '0 : wea;
  assign dm_addr  = rst ? '0 : waddr;
  assign dm_din   = rst ? '0 : din;
  assign busy     = (state_q != IDLE) & ~rst;

endmodule

// File: tb/tb_dm_access_arbiter.sv
// Self-checking bench for dm_access_arbiter: table-driven single-port transfers
// against a behavioural BRAM, plus reset, mid-operation reset and contention sequences.
module tb_dm_access_arbiter;

  logic        clk;
  logic        rst;
  logic        m0_req, m0_we, m1_req, m1_we;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic [2:0]  m0_ctrl, m1_ctrl;
  logic        m0_ack, m0_err, m1_ack, m1_err;
  logic [31:0] m0_rdata, m1_rdata;
  logic        dm_en;
  logic [3:0]  dm_wea;
  logic [9:0]  dm_addr;
  logic [31:0] dm_din, dm_dout;
  logic        busy;

  int total = 0;
  int bad   = 0;

  dm_access_arbiter #(.DM_AW(10)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_ctrl(m0_ctrl),
    .m0_ack(m0_ack), .m0_err(m0_err), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_ctrl(m1_ctrl),
    .m1_ack(m1_ack), .m1_err(m1_err), .m1_rdata(m1_rdata),
    .dm_en(dm_en), .dm_wea(dm_wea), .dm_addr(dm_addr), .dm_din(dm_din), .dm_dout(dm_dout),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural BRAM: byte write enables, one-cycle registered read.
  logic [31:0] mem [1024] = '{default: '0};
  initial dm_dout = '0;
  always @(posedge clk) begin
    if (dm_en) begin
      for (int b = 0; b < 4; b++)
        if (dm_wea[b]) mem[dm_addr][8*b +: 8] <= dm_din[8*b +: 8];
      dm_dout <= mem[dm_addr];
    end
  end

  typedef struct {
    logic        port;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  ctrl;
    logic        err;
    logic [31:0] rdata;
    logic [3:0]  wea;
    logic [31:0] din;
  } vec_t;

  vec_t vq[$];

  function automatic void add(input logic p, input logic we, input logic [31:0] a,
                              input logic [31:0] wd, input logic [2:0] c, input logic e,
                              input logic [31:0] rd, input logic [3:0] wea, input logic [31:0] din);
    vec_t v;
    v.port = p; v.we = we; v.addr = a; v.wdata = wd; v.ctrl = c;
    v.err = e; v.rdata = rd; v.wea = wea; v.din = din;
    vq.push_back(v);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic port, input logic req, input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [2:0] ctrl);
    if (port) begin
      m1_req = req; m1_we = we; m1_addr = addr; m1_wdata = wdata; m1_ctrl = ctrl;
    end else begin
      m0_req = req; m0_we = we; m0_addr = addr; m0_wdata = wdata; m0_ctrl = ctrl;
    end
  endtask

  task automatic run_op(input vec_t v, input string tag);
    int   exp_k, got_k;
    logic ack_g, ack_o, err_g;
    logic [31:0] rd_g;
    exp_k = (v.err || v.we) ? 1 : 2;
    got_k = 0;
    @(negedge clk);
    drive(v.port, 1'b1, v.we, v.addr, v.wdata, v.ctrl);
    for (int k = 1; k <= 4 && got_k == 0; k++) begin
      @(negedge clk);
      ack_g = v.port ? m1_ack   : m0_ack;
      ack_o = v.port ? m0_ack   : m1_ack;
      err_g = v.port ? m1_err   : m0_err;
      rd_g  = v.port ? m1_rdata : m0_rdata;
      check($sformatf("%s other_ack k%0d", tag, k), 32'(ack_o), 32'd0);
      if (k == 1) begin
        if (v.err) begin
          check($sformatf("%s err dm_en", tag), 32'(dm_en), 32'd0);
          check($sformatf("%s err dm_wea", tag), 32'(dm_wea), 32'd0);
        end else begin
          check($sformatf("%s dm_en", tag), 32'(dm_en), 32'd1);
          check($sformatf("%s dm_addr", tag), 32'(dm_addr), 32'(v.addr[11:2]));
          check($sformatf("%s dm_wea", tag), 32'(dm_wea), v.we ? 32'(v.wea) : 32'd0);
          if (v.we) check($sformatf("%s dm_din", tag), dm_din, v.din);
        end
      end
      if (ack_g) begin
        got_k = k;
        check($sformatf("%s err", tag), 32'(err_g), 32'(v.err));
        check($sformatf("%s rdata", tag), rd_g, v.rdata);
        drive(v.port, 1'b0, 1'b0, 32'd0, 32'd0, 3'd0);
      end
    end
    check($sformatf("%s ack_latency", tag), 32'(got_k), 32'(exp_k));
    if (got_k == 0) drive(v.port, 1'b0, 1'b0, 32'd0, 32'd0, 3'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " ctl"}, 32'({m0_ack, m0_err, m1_ack, m1_err, dm_en, dm_wea, busy}), 32'd0);
    check({tag, " data"}, m0_rdata | m1_rdata | dm_din | 32'(dm_addr), 32'd0);
  endtask

  initial begin
    vec_t v;
    logic exp0, exp1;

    rst = 1'b1;
    drive(1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 3'b000);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 3'b000);

    // Reset held two cycles with m0 requesting: everything quiet.
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check_all_zero($sformatf("reset c%0d", i));
    end
    rst = 1'b0;
    @(negedge clk);
    check("post_reset busy", 32'(busy), 32'd1);
    check("post_reset dm_en", 32'(dm_en), 32'd1);
    @(negedge clk);
    check("post_reset m0_ack", 32'(m0_ack), 32'd1);
    check("post_reset m0_rdata", m0_rdata, 32'd0);
    m0_req = 1'b0;

    //   port we  addr          wdata         ctrl    err rdata         wea      din
    add(1'b0, 1, 32'h00000006, 32'h000000AB, 3'b011, 0, 32'h0,        4'b0100, 32'hABABABAB);
    add(1'b1, 0, 32'h00000004, 32'h0,        3'b000, 0, 32'h00AB0000, 4'b0000, 32'h0);
    add(1'b1, 1, 32'h00000004, 32'h8001F00F, 3'b000, 0, 32'h0,        4'b1111, 32'h8001F00F);
    add(1'b1, 0, 32'h00000006, 32'h0,        3'b001, 0, 32'hFFFF8001, 4'b0000, 32'h0);
    add(1'b1, 0, 32'h00000006, 32'h0,        3'b010, 0, 32'h00008001, 4'b0000, 32'h0);
    add(1'b1, 0, 32'h00000004, 32'h0,        3'b011, 0, 32'h0000000F, 4'b0000, 32'h0);
    add(1'b0, 0, 32'h00000005, 32'h0,        3'b011, 0, 32'hFFFFFFF0, 4'b0000, 32'h0);
    add(1'b0, 0, 32'h00000005, 32'h0,        3'b100, 0, 32'h000000F0, 4'b0000, 32'h0);
    add(1'b0, 0, 32'h00000007, 32'h0,        3'b011, 0, 32'hFFFFFF80, 4'b0000, 32'h0);
    add(1'b0, 0, 32'h00000004, 32'h0,        3'b001, 0, 32'hFFFFF00F, 4'b0000, 32'h0);
    add(1'b0, 1, 32'h0000000A, 32'h00001234, 3'b010, 0, 32'h0,        4'b1100, 32'h12341234);
    add(1'b1, 0, 32'h00000008, 32'h0,        3'b000, 0, 32'h12340000, 4'b0000, 32'h0);
    add(1'b1, 1, 32'h00000009, 32'hFFFFFF5A, 3'b100, 0, 32'h0,        4'b0010, 32'h5A5A5A5A);
    add(1'b0, 0, 32'h00000008, 32'h0,        3'b000, 0, 32'h12345A00, 4'b0000, 32'h0);
    add(1'b0, 1, 32'h00000002, 32'h12345678, 3'b000, 1, 32'h0,        4'b0000, 32'h0);
    add(1'b0, 0, 32'h00000000, 32'h0,        3'b000, 0, 32'h00000000, 4'b0000, 32'h0);
    add(1'b1, 0, 32'h00000005, 32'h0,        3'b001, 1, 32'h0,        4'b0000, 32'h0);
    add(1'b0, 0, 32'h00000003, 32'h0,        3'b000, 1, 32'h0,        4'b0000, 32'h0);
    add(1'b0, 1, 32'h00000010, 32'h11223344, 3'b000, 0, 32'h0,        4'b1111, 32'h11223344);
    add(1'b1, 0, 32'h00000010, 32'h0,        3'b111, 0, 32'h11223344, 4'b0000, 32'h0);

    foreach (vq[i]) run_op(vq[i], $sformatf("v%0d", i));

    // Reset lands in the ISSUE cycle of an m1 word store: the write must not reach memory.
    @(negedge clk);
    drive(1'b1, 1'b1, 1'b1, 32'h00000010, 32'hDEADBEEF, 3'b000);
    @(negedge clk);
    check("midrst pre dm_wea", 32'(dm_wea), 32'hF);
    rst = 1'b1;
    #1;
    check("midrst dm_wea", 32'(dm_wea), 32'd0);
    check("midrst dm_en", 32'(dm_en), 32'd0);
    check("midrst m1_ack", 32'(m1_ack), 32'd0);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 3'b000);
    @(negedge clk);
    check("midrst m1_ack2", 32'(m1_ack), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("midrst busy", 32'(busy), 32'd0);
    v.port = 1'b0; v.we = 1'b0; v.addr = 32'h10; v.wdata = '0; v.ctrl = 3'b000;
    v.err = 1'b0; v.rdata = 32'h11223344; v.wea = '0; v.din = '0;
    run_op(v, "midrst readback");

    // Contention after reset: m0 first, then strict alternation, one ack every 3 cycles.
    @(negedge clk);
    drive(1'b0, 1'b1, 1'b0, 32'h00000004, 32'h0, 3'b000);
    drive(1'b1, 1'b1, 1'b0, 32'h00000010, 32'h0, 3'b000);
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      exp0 = (k == 2) || (k == 8);
      exp1 = (k == 5) || (k == 11);
      check($sformatf("contend m0_ack k%0d", k), 32'(m0_ack), 32'(exp0));
      check($sformatf("contend m1_ack k%0d", k), 32'(m1_ack), 32'(exp1));
      if (exp0) check($sformatf("contend m0_rdata k%0d", k), m0_rdata, 32'h8001F00F);
      if (exp1) check($sformatf("contend m1_rdata k%0d", k), m1_rdata, 32'h11223344);
      if (k == 11) begin
        m0_req = 1'b0;
        m1_req = 1'b0;
      end
    end
    check("contend idle busy", 32'(busy), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
